mem_arbiter: RTL

- Sole owner of the 8-bit RAM/IO port. Arbitrates between instruction fetch (IF, word reads only) and the load/store buffer (LS, 1/2/4-byte loads and stores).
- Serialises each request into byte beats, assembles load data little-endian, and returns a one-cycle ok pulse.
- The LS-side handshake matches the LS buffer's existing flag/ok protocol.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_beat_seq.sv | 66 ++++++
 rtl/mem_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial memory arbiter: sizes, FSM states, owners.
package mem_arbiter_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] IO_HI_DFLT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  // Size 3 is illegal on the LS side and behaves as a word.
  function automatic logic [2:0] size_len(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/mem_beat_seq.sv
// Byte-beat sequencer: walks mem_a across the request, drives store bytes and
// assembles load bytes little-endian into buffer.
module mem_beat_seq
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_A_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               step,
  input  logic               st_wr,
  input  logic [1:0]         st_size,
  input  logic [RAM_A_W-1:0] st_addr,
  input  logic [31:0]        st_wdata,
  input  logic [7:0]         mem_din,
  output logic               fin,
  output logic [31:0]        buffer,
  output logic [RAM_A_W-1:0] mem_a,
  output logic [7:0]         mem_dout,
  output logic               mem_wr
);
  logic [2:0]  cnt, len;
  logic        wr;
  logic [31:0] wdata;
  logic [1:0]  bidx;

  // Reads need one extra edge to capture the byte of the final beat.
  assign fin  = wr ? (cnt == len) : (cnt == len + 3'd1);
  assign bidx = cnt[1:0] - 2'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      len      <= '0;
      wr       <= 1'b0;
      wdata    <= '0;
      buffer   <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr   <= 1'b0;
    end else if (en) begin
      if (start) begin
        cnt      <= 3'd1;
        len      <= size_len(st_size);
        wr       <= st_wr;
        wdata    <= st_wdata;
        buffer   <= '0;
        mem_a    <= st_addr;
        mem_dout <= st_wdata[7:0];
        mem_wr   <= st_wr;
      end else if (step) begin
        if (!wr && cnt != 3'd0 && cnt <= len)
          buffer[{bidx, 3'b000} +: 8] <= mem_din;
        if (cnt < len) begin
          mem_a    <= mem_a + RAM_A_W'(1);
          mem_dout <= wdata[{cnt[1:0], 3'b000} +: 8];
        end else begin
          mem_wr <= 1'b0;
        end
        if (!fin) cnt <= cnt + 3'd1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Owner of the 8-bit RAM/IO port: arbitrates IF word fetches against LS accesses.
// Optional macro IO_BUFFER_STALL_EN holds IO-window stores while io_buffer_full.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         ADDR_W  = 32,
  parameter int         RAM_A_W = 32,
  parameter logic [1:0] IO_HI   = IO_HI_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clr,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_ok,
  output logic [31:0]        if_data,
  input  logic               ls_req,
  input  logic               ls_wr,
  input  logic [1:0]         ls_size,
  input  logic [ADDR_W-1:0]  ls_addr,
  input  logic [31:0]        ls_wdata,
  output logic               ls_ok,
  output logic [31:0]        ls_rdata,
  input  logic [7:0]         mem_din,
  output logic [7:0]         mem_dout,
  output logic [RAM_A_W-1:0] mem_a,
  output logic               mem_wr,
  input  logic               io_buffer_full
);
  state_t      state;
  owner_t      owner;
  logic        if_prio, if_ok_q, ls_ok_q, mem_wr_q;
  logic        io_hit, io_stall, if_go, ls_go, pick_if, accept, fin;
  logic [31:0] buffer;

  assign io_hit = ls_wr && (ls_addr[17:16] == IO_HI) && io_buffer_full;
`ifdef IO_BUFFER_STALL_EN
  assign io_stall = io_hit;
`else
  assign io_stall = 1'b0 && io_hit;
`endif

  assign if_go   = if_req && !clr;
  assign ls_go   = ls_req && !io_stall;
  assign pick_if = if_go && (if_prio || !ls_go);
  assign accept  = if_go || ls_go;

  mem_beat_seq #(.RAM_A_W(RAM_A_W)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy),
    .start    (state == S_IDLE && accept),
    .step     (state == S_BUSY),
    .st_wr    (pick_if ? 1'b0 : ls_wr),
    .st_size  (pick_if ? SZ_W : ls_size),
    .st_addr  (RAM_A_W'(pick_if ? if_addr : ls_addr)),
    .st_wdata (ls_wdata),
    .mem_din  (mem_din),
    .fin      (fin),
    .buffer   (buffer),
    .mem_a    (mem_a),
    .mem_dout (mem_dout),
    .mem_wr   (mem_wr_q)
  );

  // A frozen or flushed cycle must never look like a write or a fetch completion.
  assign mem_wr = mem_wr_q & rdy;
  assign if_ok  = if_ok_q & rdy & ~clr;
  assign ls_ok  = ls_ok_q & rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      owner    <= OWN_IF;
      if_prio  <= 1'b0;
      if_ok_q  <= 1'b0;
      ls_ok_q  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
    end else if (rdy) begin
      if_ok_q <= 1'b0;
      ls_ok_q <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          owner   <= pick_if ? OWN_IF : OWN_LS;
          if_prio <= 1'b0;
          state   <= S_BUSY;
        end
        S_BUSY: begin
          if (owner == OWN_IF && clr) begin
            state <= S_IDLE;
          end else if (fin) begin
            state <= S_DONE;
            if (owner == OWN_IF) begin
              if_ok_q <= 1'b1;
              if_data <= buffer;
            end else begin
              ls_ok_q  <= 1'b1;
              ls_rdata <= buffer;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          // A fetch left waiting behind a load/store goes next.
          if (owner == OWN_LS) if_prio <= if_req;
        end
      endcase
    end
  end
endmodule
